// File: rtl/mem_arbiter_pkg.sv
// mem_arb_types: shared definitions for the N-channel memory arbiter.
//   arb_state_e   - arbiter FSM states (IDLE, BUSY)
//   ARB_FIXED/RR  - priority-mode selectors fed to arb_picker
//   clog2_min1    - ceil(log2(v)) clamped to at least 1, for index/counter widths
package mem_arb_types;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR    = 1'b1;

    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/mem_arbiter_picker.sv
// arb_picker: combinational winner selection for mem_arbiter.
//   req_i        - request vector, one bit per channel
//   last_grant_i - most recently granted channel (round-robin pointer)
//   mode_i       - ARB_FIXED: lowest index wins; ARB_RR: search from last_grant_i+1
//   winner_o     - selected channel index (0 when no request)
//   valid_o      - at least one request present
module arb_picker
    import mem_arb_types::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned GW     = 1
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [GW-1:0]     last_grant_i,
    input  logic              mode_i,
    output logic [GW-1:0]     winner_o,
    output logic              valid_o
);

    logic [2*NUM_CH-1:0] dbl;
    logic [NUM_CH-1:0]   rot;
    int unsigned         start;
    int unsigned         idx;
    logic                found;

    // Requests are duplicated side by side so that shifting right by the
    // start position yields the wrapped search order in the low NUM_CH bits;
    // a plain lowest-bit priority encode then finds the winner.
    always_comb begin
        dbl   = {req_i, req_i};
        start = 0;
        if (mode_i == ARB_RR) begin
            start = 32'(last_grant_i) + 1;
            if (start >= NUM_CH) start = 0;
        end
        rot      = NUM_CH'(dbl >> start);
        valid_o  = |req_i;
        found    = 1'b0;
        idx      = 0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                idx   = start + i;
                if (idx >= NUM_CH) idx = idx - NUM_CH;
            end
        end
        winner_o = GW'(idx);
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: merges NUM_CH requester memory ports onto one downstream port.
//   clk, rst                 - clock; asynchronous active-low reset
//   ch_address/read/write/byte_enable/wdata - packed per-channel requests
//   ch_rdata                 - read data broadcast (mem_rdata pass-through)
//   ch_resp                  - per-channel one-cycle completion pulse
//   mem_address/read/write/byte_enable/wdata - registered downstream request
//   mem_rdata, mem_resp      - downstream read data and completion
//   grant_id, busy           - served channel / transaction outstanding
//   timeout_err              - sticky watchdog flag (TIMEOUT=0 disables)
module mem_arbiter
    import mem_arb_types::*;
#(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter bit          RR_MODE = 1'b1,
    parameter int unsigned TIMEOUT = 0,
    localparam int unsigned BE_W   = DATA_W / 8,
    localparam int unsigned GW     = clog2_min1(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*ADDR_W-1:0] ch_address,
    input  logic [NUM_CH-1:0]        ch_read,
    input  logic [NUM_CH-1:0]        ch_write,
    input  logic [NUM_CH*BE_W-1:0]   ch_byte_enable,
    input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
    output logic [DATA_W-1:0]        ch_rdata,
    output logic [NUM_CH-1:0]        ch_resp,
    output logic [ADDR_W-1:0]        mem_address,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [BE_W-1:0]          mem_byte_enable,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_resp,
    output logic [GW-1:0]            grant_id,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int unsigned CW = clog2_min1(TIMEOUT + 1);

    // Field widths track the module parameters, so the latched-request
    // record is declared here rather than in the shared package.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
        logic              is_write;
    } mem_req_t;

    arb_state_e        state_q, state_d;
    mem_req_t          req_q, req_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [GW-1:0]     last_q, last_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              err_q, err_d;

    logic [GW-1:0]     winner;
    logic              win_valid;
    int unsigned       w;

    arb_picker #(
        .NUM_CH (NUM_CH),
        .GW     (GW)
    ) u_picker (
        .req_i        (ch_read | ch_write),
        .last_grant_i (last_q),
        .mode_i       (RR_MODE ? ARB_RR : ARB_FIXED),
        .winner_o     (winner),
        .valid_o      (win_valid)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        grant_d = grant_q;
        last_d  = last_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ch_resp = '0;
        w       = 32'(winner);
        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d        = BUSY;
                    grant_d        = winner;
                    last_d         = winner;
                    req_d.addr     = ch_address[w*ADDR_W +: ADDR_W];
                    req_d.be       = ch_byte_enable[w*BE_W +: BE_W];
                    req_d.wdata    = ch_wdata[w*DATA_W +: DATA_W];
                    // Read+write together resolves to a write.
                    req_d.is_write = ch_write[w];
                    wr_d           = ch_write[w];
                    rd_d           = ~ch_write[w];
                    cnt_d          = '0;
                end
            end
            BUSY: begin
                if (mem_resp) begin
                    for (int unsigned i = 0; i < NUM_CH; i++) begin
                        ch_resp[i] = (32'(grant_q) == i);
                    end
                    state_d = IDLE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                end else if (TIMEOUT != 0 && cnt_q != CW'(TIMEOUT)) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CW'(TIMEOUT)) err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            req_q   <= '0;
            grant_q <= '0;
            last_q  <= GW'(NUM_CH - 1);
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign ch_rdata        = mem_rdata;
    assign mem_address     = req_q.addr;
    assign mem_byte_enable = req_q.be;
    assign mem_wdata       = req_q.wdata;
    assign mem_read        = rd_q;
    assign mem_write       = wr_q;
    assign grant_id        = grant_q;
    assign busy            = (state_q == BUSY);
    assign timeout_err     = err_q;

    a_no_rd_wr : assert property (@(posedge clk) disable iff (!rst)
        (ch_read & ch_write) == '0);

endmodule
